// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris active-piece datapath: command codes,
// controller states, shape codes and default board geometry.
package tetris_pkg;

   localparam int DEF_COLS    = 10;
   localparam int DEF_ROWS    = 20;
   localparam int DEF_SPAWN_X = 3;

   typedef enum logic [1:0] {
      CMD_LEFT  = 2'b00,
      CMD_RIGHT = 2'b01,
      CMD_ROT   = 2'b10,
      CMD_DOWN  = 2'b11
   } cmd_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CHECK0,
      ST_CHECK1,
      ST_CHECK2,
      ST_CHECK3,
      ST_RESOLVE,
      ST_ACTIVE,
      ST_LOCK,
      ST_OVER
   } state_e;

   localparam logic [2:0] SHAPE_T = 3'd1;
   localparam logic [2:0] SHAPE_Z = 3'd2;
   localparam logic [2:0] SHAPE_S = 3'd3;
   localparam logic [2:0] SHAPE_J = 3'd4;
   localparam logic [2:0] SHAPE_L = 3'd5;
   localparam logic [2:0] SHAPE_O = 3'd6;
   localparam logic [2:0] SHAPE_I = 3'd7;

   // Row r of the 4x4 mask sits in the nibble whose MSB is column 0.
   function automatic logic [3:0] mask_row_sel(input logic [15:0] mask, input logic [1:0] r);
      case (r)
         2'd0:    return mask[15:12];
         2'd1:    return mask[11:8];
         2'd2:    return mask[7:4];
         default: return mask[3:0];
      endcase
   endfunction

endpackage

// File: rtl/piece_ctrl_row_collide.sv
// Collision test of one 4-cell mask row against one board row, with the
// box left edge at a signed column that may sit off either side of the board.
module row_collide
   import tetris_pkg::*;
#(
   parameter int COLS = DEF_COLS
) (
   input  logic [3:0]      mask_row,
   input  logic [4:0]      x,
   input  logic            row_oor,
   input  logic [COLS-1:0] row_data,
   output logic            collide
);

   localparam logic signed [5:0] COLS_S = 6'(COLS);

   always_comb begin
      logic signed [5:0] col;
      collide = 1'b0;
      col     = '0;
      for (int c = 0; c < 4; c++) begin
         col = {x[4], x} + 6'(c);
         if (mask_row[3-c]) begin
            if (row_oor || (col < 6'sd0) || (col >= COLS_S)) begin
               collide = 1'b1;
            end else begin
               for (int i = 0; i < COLS; i++) begin
                  if ((col == 6'(i)) && row_data[i]) begin
                     collide = 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller: spawns pieces, checks each candidate move against
// the board one row per cycle, then commits, rejects or locks the piece.
module piece_ctrl
   import tetris_pkg::*;
#(
   parameter int COLS    = DEF_COLS,
   parameter int ROWS    = DEF_ROWS,
   parameter int SPAWN_X = DEF_SPAWN_X
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            spawn_valid,
   input  logic [2:0]      spawn_shape,
   output logic            spawn_ready,
   input  logic            cmd_valid,
   input  logic [1:0]      cmd,
   output logic            cmd_ready,
   output logic [2:0]      dec_shape,
   output logic [1:0]      dec_rot,
   input  logic [15:0]     dec_mask,
   output logic [4:0]      row_addr,
   input  logic [COLS-1:0] row_data,
   output logic [2:0]      shape,
   output logic [1:0]      rot,
   output logic [4:0]      pos_x,
   output logic [4:0]      pos_y,
   output logic            active,
   output logic            lock_valid,
   output logic            game_over
);

   localparam logic [5:0] ROWS6 = 6'(ROWS);

   state_e      state_q, state_d;
   logic [2:0]  cand_shape_q, cand_shape_d;
   logic [1:0]  cand_rot_q, cand_rot_d;
   logic [4:0]  cand_x_q, cand_x_d;
   logic [4:0]  cand_y_q, cand_y_d;
   logic [1:0]  cand_cmd_q, cand_cmd_d;
   logic        cand_spawn_q, cand_spawn_d;
   logic        collide_q, collide_d;
   logic [2:0]  shape_q, shape_d;
   logic [1:0]  rot_q, rot_d;
   logic [4:0]  pos_x_q, pos_x_d;
   logic [4:0]  pos_y_q, pos_y_d;
   logic        active_q, active_d;

   logic        in_check;
   logic [1:0]  chk_r;
   logic [5:0]  row_sum;
   logic        row_oor;
   logic        row_hit;

   always_comb begin
      in_check = 1'b1;
      chk_r    = 2'd0;
      case (state_q)
         ST_CHECK0: chk_r = 2'd0;
         ST_CHECK1: chk_r = 2'd1;
         ST_CHECK2: chk_r = 2'd2;
         ST_CHECK3: chk_r = 2'd3;
         default:   in_check = 1'b0;
      endcase
      row_sum = {1'b0, cand_y_q} + {4'b0000, chk_r};
      row_oor = (row_sum >= ROWS6);
   end

   row_collide #(.COLS(COLS)) u_row_collide (
      .mask_row (mask_row_sel(dec_mask, chk_r)),
      .x        (cand_x_q),
      .row_oor  (row_oor),
      .row_data (row_data),
      .collide  (row_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cand_shape_q <= '0;
         cand_rot_q   <= '0;
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         cand_cmd_q   <= '0;
         cand_spawn_q <= 1'b0;
         collide_q    <= 1'b0;
         shape_q      <= '0;
         rot_q        <= '0;
         pos_x_q      <= '0;
         pos_y_q      <= '0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cand_shape_q <= cand_shape_d;
         cand_rot_q   <= cand_rot_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         cand_cmd_q   <= cand_cmd_d;
         cand_spawn_q <= cand_spawn_d;
         collide_q    <= collide_d;
         shape_q      <= shape_d;
         rot_q        <= rot_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         active_q     <= active_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cand_shape_d = cand_shape_q;
      cand_rot_d   = cand_rot_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      cand_cmd_d   = cand_cmd_q;
      cand_spawn_d = cand_spawn_q;
      collide_d    = collide_q;
      shape_d      = shape_q;
      rot_d        = rot_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      active_d     = active_q;
      case (state_q)
         ST_IDLE: begin
            if (spawn_valid) begin
               cand_shape_d = spawn_shape;
               cand_rot_d   = 2'd0;
               cand_x_d     = 5'(SPAWN_X);
               cand_y_d     = 5'd0;
               cand_spawn_d = 1'b1;
               collide_d    = 1'b0;
               state_d      = ST_CHECK0;
            end
         end
         ST_ACTIVE: begin
            if (cmd_valid) begin
               cand_shape_d = shape_q;
               cand_rot_d   = rot_q;
               cand_x_d     = pos_x_q;
               cand_y_d     = pos_y_q;
               cand_cmd_d   = cmd;
               cand_spawn_d = 1'b0;
               collide_d    = 1'b0;
               case (cmd)
                  CMD_LEFT:  cand_x_d   = pos_x_q - 5'd1;
                  CMD_RIGHT: cand_x_d   = pos_x_q + 5'd1;
                  CMD_ROT:   cand_rot_d = rot_q + 2'd1;
                  default:   cand_y_d   = pos_y_q + 5'd1;
               endcase
               state_d = ST_CHECK0;
            end
         end
         ST_CHECK0: begin
            collide_d = collide_q | row_hit;
            state_d   = ST_CHECK1;
         end
         ST_CHECK1: begin
            collide_d = collide_q | row_hit;
            state_d   = ST_CHECK2;
         end
         ST_CHECK2: begin
            collide_d = collide_q | row_hit;
            state_d   = ST_CHECK3;
         end
         ST_CHECK3: begin
            collide_d = collide_q | row_hit;
            state_d   = ST_RESOLVE;
         end
         // A blocked spawn ends the game, a blocked drop lands the piece,
         // and a blocked sideways/rotate move is simply dropped.
         ST_RESOLVE: begin
            if (!collide_q) begin
               shape_d  = cand_shape_q;
               rot_d    = cand_rot_q;
               pos_x_d  = cand_x_q;
               pos_y_d  = cand_y_q;
               active_d = 1'b1;
               state_d  = ST_ACTIVE;
            end else if (cand_spawn_q) begin
               state_d = ST_OVER;
            end else if (cand_cmd_q == CMD_DOWN) begin
               active_d = 1'b0;
               state_d  = ST_LOCK;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_LOCK: state_d = ST_IDLE;
         ST_OVER: state_d = ST_OVER;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      spawn_ready = (state_q == ST_IDLE);
      cmd_ready   = (state_q == ST_ACTIVE);
      lock_valid  = (state_q == ST_LOCK);
      game_over   = (state_q == ST_OVER);
      row_addr    = in_check ? row_sum[4:0] : 5'd0;
      dec_shape   = in_check ? cand_shape_q : shape_q;
      dec_rot     = in_check ? cand_rot_q : rot_q;
      shape       = shape_q;
      rot         = rot_q;
      pos_x       = pos_x_q;
      pos_y       = pos_y_q;
      active      = active_q;
   end

endmodule

// File: tb/tb_piece_ctrl.sv
// Scoreboard bench for piece_ctrl: directed spawns and moves push expected
// results; a negedge monitor pops them when the DUT commits, locks or ends.
module tb_piece_ctrl;
   import tetris_pkg::*;

   localparam int COLS = 10;
   localparam int ROWS = 20;

   localparam logic [1:0] EV_ACT  = 2'd0;
   localparam logic [1:0] EV_LOCK = 2'd1;
   localparam logic [1:0] EV_OVER = 2'd2;

   typedef struct {
      logic [1:0] kind;
      logic [2:0] shape;
      logic [1:0] rot;
      logic [4:0] x;
      logic [4:0] y;
      logic       active;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            spawn_valid = 1'b0;
   logic [2:0]      spawn_shape = 3'd0;
   logic            spawn_ready;
   logic            cmd_valid = 1'b0;
   logic [1:0]      cmd = 2'd0;
   logic            cmd_ready;
   logic [2:0]      dec_shape;
   logic [1:0]      dec_rot;
   logic [15:0]     dec_mask;
   logic [4:0]      row_addr;
   logic [COLS-1:0] row_data;
   logic [2:0]      shape;
   logic [1:0]      rot;
   logic [4:0]      pos_x;
   logic [4:0]      pos_y;
   logic            active;
   logic            lock_valid;
   logic            game_over;

   logic [COLS-1:0] board [ROWS];
   exp_t            exp_q [$];
   int              checks = 0;
   int              errors = 0;
   logic            prev_cmd_ready = 1'b0;
   logic            prev_game_over = 1'b0;

   piece_ctrl #(.COLS(COLS), .ROWS(ROWS), .SPAWN_X(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .spawn_valid (spawn_valid),
      .spawn_shape (spawn_shape),
      .spawn_ready (spawn_ready),
      .cmd_valid   (cmd_valid),
      .cmd         (cmd),
      .cmd_ready   (cmd_ready),
      .dec_shape   (dec_shape),
      .dec_rot     (dec_rot),
      .dec_mask    (dec_mask),
      .row_addr    (row_addr),
      .row_data    (row_data),
      .shape       (shape),
      .rot         (rot),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .active      (active),
      .lock_valid  (lock_valid),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   // Shape decoder: T in all four rotations, O for every other code.
   always_comb begin
      dec_mask = 16'hCC00;
      if (dec_shape == SHAPE_T) begin
         case (dec_rot)
            2'd0:    dec_mask = 16'h4E00;
            2'd1:    dec_mask = 16'h4640;
            2'd2:    dec_mask = 16'h0E40;
            default: dec_mask = 16'h4C40;
         endcase
      end
   end

   always_comb begin
      row_data = '0;
      if (row_addr < 5'(ROWS)) row_data = board[row_addr];
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [1:0] kind;
      logic       seen;
      exp_t       e;
      seen = 1'b0;
      kind = EV_ACT;
      if (cmd_ready === 1'b1 && !prev_cmd_ready) begin
         seen = 1'b1;
         kind = EV_ACT;
      end else if (lock_valid === 1'b1) begin
         seen = 1'b1;
         kind = EV_LOCK;
      end else if (game_over === 1'b1 && !prev_game_over) begin
         seen = 1'b1;
         kind = EV_OVER;
      end
      if (seen) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_event", 32'(kind), 32'hFF);
         end else begin
            e = exp_q.pop_front();
            check_output("ev_kind",   32'(kind),   32'(e.kind));
            check_output("ev_shape",  32'(shape),  32'(e.shape));
            check_output("ev_rot",    32'(rot),    32'(e.rot));
            check_output("ev_pos_x",  32'(pos_x),  32'(e.x));
            check_output("ev_pos_y",  32'(pos_y),  32'(e.y));
            check_output("ev_active", 32'(active), 32'(e.active));
         end
      end
      prev_cmd_ready = (cmd_ready === 1'b1);
      prev_game_over = (game_over === 1'b1);
   end

   // Called at a negedge; returns at the negedge of cycle 6 after handshake.
   task automatic apply_stimulus(input bit is_spawn, input logic [2:0] val, input exp_t e);
      exp_q.push_back(e);
      if (is_spawn) begin
         check_output("spawn_ready_offer", 32'(spawn_ready), 32'd1);
         spawn_valid = 1'b1;
         spawn_shape = val;
      end else begin
         check_output("cmd_ready_offer", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b1;
         cmd       = val[1:0];
      end
      @(posedge clk);
      #1;
      spawn_valid = 1'b0;
      cmd_valid   = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 5) check_output(is_spawn ? "spawn_ready_busy" : "cmd_ready_busy",
                                  32'(is_spawn ? spawn_ready : cmd_ready), 32'd0);
      end
      @(negedge clk);
   endtask

   function automatic exp_t mk(input logic [1:0] kind, input logic [2:0] s, input logic [1:0] r,
                               input logic [4:0] x, input logic [4:0] y, input logic a);
      exp_t e;
      e.kind = kind; e.shape = s; e.rot = r; e.x = x; e.y = y; e.active = a;
      return e;
   endfunction

   initial begin
      for (int r = 0; r < ROWS; r++) board[r] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_spawn_ready", 32'(spawn_ready), 32'd1);
      check_output("rst_cmd_ready",   32'(cmd_ready),   32'd0);
      check_output("rst_active",      32'(active),      32'd0);
      check_output("rst_lock_valid",  32'(lock_valid),  32'd0);
      check_output("rst_game_over",   32'(game_over),   32'd0);
      check_output("rst_pos",         32'({shape, rot, pos_x, pos_y}), 32'd0);
      check_output("rst_row_addr",    32'(row_addr),    32'd0);
      rst = 1'b0;
      @(negedge clk);

      apply_stimulus(1'b1, SHAPE_O, mk(EV_ACT, 3'd6, 2'd0, 5'd3, 5'd0, 1'b1));
      check_output("spawn_game_over", 32'(game_over), 32'd0);

      for (int i = 1; i <= 3; i++)
         apply_stimulus(1'b0, {1'b0, CMD_LEFT}, mk(EV_ACT, 3'd6, 2'd0, 5'(3 - i), 5'd0, 1'b1));
      apply_stimulus(1'b0, {1'b0, CMD_LEFT}, mk(EV_ACT, 3'd6, 2'd0, 5'd0, 5'd0, 1'b1));

      for (int i = 1; i <= 3; i++)
         apply_stimulus(1'b0, {1'b0, CMD_RIGHT}, mk(EV_ACT, 3'd6, 2'd0, 5'(i), 5'd0, 1'b1));

      for (int i = 1; i <= 18; i++)
         apply_stimulus(1'b0, {1'b0, CMD_DOWN}, mk(EV_ACT, 3'd6, 2'd0, 5'd3, 5'(i), 1'b1));
      apply_stimulus(1'b0, {1'b0, CMD_DOWN}, mk(EV_LOCK, 3'd6, 2'd0, 5'd3, 5'd18, 1'b0));
      @(negedge clk);
      check_output("lock_pulse_one_cycle", 32'(lock_valid),  32'd0);
      check_output("idle_after_lock",      32'(spawn_ready), 32'd1);

      apply_stimulus(1'b1, SHAPE_T, mk(EV_ACT, 3'd1, 2'd0, 5'd3, 5'd0, 1'b1));
      for (int i = 1; i <= 4; i++)
         apply_stimulus(1'b0, {1'b0, CMD_ROT}, mk(EV_ACT, 3'd1, 2'(i), 5'd3, 5'd0, 1'b1));

      // Reset in the third check row of a drop: nothing may commit or lock.
      cmd_valid = 1'b1;
      cmd       = CMD_DOWN;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_output("check2_row_addr", 32'(row_addr), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("midrst_spawn_ready", 32'(spawn_ready), 32'd1);
      check_output("midrst_lock_valid",  32'(lock_valid),  32'd0);
      check_output("midrst_active",      32'(active),      32'd0);
      check_output("midrst_pos",         32'({shape, rot, pos_x, pos_y}), 32'd0);
      repeat (6) @(negedge clk);
      check_output("midrst_no_commit",   32'({cmd_ready, lock_valid}), 32'd0);

      board[0] = '1;
      apply_stimulus(1'b1, SHAPE_T, mk(EV_OVER, 3'd0, 2'd0, 5'd0, 5'd0, 1'b0));
      spawn_valid = 1'b1;
      spawn_shape = SHAPE_O;
      cmd_valid   = 1'b1;
      cmd         = CMD_DOWN;
      repeat (8) @(negedge clk);
      check_output("over_spawn_ready", 32'(spawn_ready), 32'd0);
      check_output("over_cmd_ready",   32'(cmd_ready),   32'd0);
      check_output("over_sticky",      32'(game_over),   32'd1);
      check_output("over_active",      32'(active),      32'd0);
      spawn_valid = 1'b0;
      cmd_valid   = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("over_rst_game_over",   32'(game_over),   32'd0);
      check_output("over_rst_spawn_ready", 32'(spawn_ready), 32'd1);
      @(negedge clk);

      check_output("pending_events", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
